// File: rtl/serial_logic_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_logic_unit_if
//  Description : Operand-in / result-out handshake bundle for the bit-serial
//                logic engine.
//                  in_valid/in_ready  operand handshake (a, b, op)
//                  out_valid/out_ready result handshake (y, zero)
//                master = operand producer / result consumer
//                slave  = the logic engine itself
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_logic_unit
//  Description : Bit-serial two-operand logic engine. Accepts WIDTH-bit
//                operands a/b and a 2-bit opcode (00 AND, 01 OR, 10 XOR,
//                11 NAND), evaluates one bit per clock LSB first, and
//                presents the assembled result on y.
//  Ports       : clk   rising-edge clock
//                rst   asynchronous active-high reset
//                bus   serial_logic_unit_if.slave
//                        in_valid/in_ready, a, b, op    operand side
//                        out_valid/out_ready, y, zero   result side
//  Revision    : 1.0  initial release
// ============================================================================
module serial_logic_unit #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_logic_unit_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_op_and  = 2'b00;
    localparam logic [1:0] c_op_or   = 2'b01;
    localparam logic [1:0] c_op_xor  = 2'b10;
    localparam logic [1:0] c_op_nand = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_res;   // assembly register, shifts during SHIFT
    logic [WIDTH-1:0] r_y;     // presented result, stable outside the final SHIFT edge
    logic [CNT_W-1:0] r_cnt;
    logic             w_bit;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    assign w_last = (r_cnt == c_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = SHIFT;
            SHIFT:   if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One-bit logic evaluation on the current LSBs
    // ------------------------------------------------------------------
    always_comb begin
        w_bit = 1'b0;
        case (r_op)
            c_op_and:  w_bit = r_a[0] & r_b[0];
            c_op_or:   w_bit = r_a[0] | r_b[0];
            c_op_xor:  w_bit = r_a[0] ^ r_b[0];
            c_op_nand: w_bit = ~(r_a[0] & r_b[0]);
            default:   w_bit = 1'b0;
        endcase
    end

    // New bit enters at the MSB; after WIDTH shifts bit i lines up with
    // operand bit i. A 1-bit result has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_bit;
        end else begin : g_res_wn
            assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_res <= '0;
            r_y   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_op  <= bus.op;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    // y only changes when a complete result exists, so the
                    // previous result stays visible while shifting.
                    if (w_last) begin
                        r_y <= w_res_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.y         = r_y;
    assign bus.zero      = (r_state == DONE) && (r_y == '0);

endmodule
`default_nettype wire
